// File: rtl/radix4_pkg.sv
// Shared definitions for the iterative multiplier sequencer.
//   state_e       : sequencer state encoding (IDLE / RUN / DONE)
//   clog2()       : constant ceiling-log2, used to size the iteration counter
//   iter_total()  : number of add/shift iterations for a given operand width and radix
package radix4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

  // Radix-4 retires two operand bits per iteration, radix-2 one.
  function automatic int iter_total(input int width, input bit r4);
    return r4 ? (width / 2) : width;
  endfunction

endpackage

// File: rtl/cnt_zero_det.sv
// Zero detector for the iteration counter.
//   i_count : counter value, W bits
//   o_zero  : 1 when i_count is all zeros (pure combinational NOR reduction)
module cnt_zero_det #(
  parameter int W = 3
) (
  input  logic [W-1:0] i_count,
  output logic         o_zero
);

  assign o_zero = ~|i_count;

endmodule

// File: rtl/iter_seq_ctrl.sv
// Iteration sequencer for a radix-2 / radix-4 shift-add multiplier.
// Counts down the remaining iterations, issues one datapath step per
// un-held cycle, flags the final iteration and pulses done on completion.
//
// Ports
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset
//   start    : begin a sequence (honoured only in IDLE)
//   r4_mode  : 1 = radix-4 (WIDTH/2 iterations), 0 = radix-2 (WIDTH iterations)
//   hold     : stall; no step and no count change while high
//   abort    : cancel a running sequence, back to IDLE without done
//   busy     : sequence in progress (RUN or DONE)
//   step     : datapath add/shift enable this cycle
//   last     : this step is the final iteration
//   done     : one-cycle completion pulse
//   count    : remaining iterations minus one
//   zero     : count == 0
//
// state | meaning
// IDLE  | waiting for start, count held at 0
// RUN   | one iteration per cycle unless held
// DONE  | completion pulse, back to IDLE next edge
module iter_seq_ctrl
  import radix4_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          r4_mode,
  input  logic          hold,
  input  logic          abort,
  output logic          busy,
  output logic          step,
  output logic          last,
  output logic          done,
  output logic [CW-1:0] count,
  output logic          zero
);

  localparam logic [CW-1:0] LOAD_R4 = CW'(iter_total(WIDTH, 1'b1) - 1);
  localparam logic [CW-1:0] LOAD_R2 = CW'(iter_total(WIDTH, 1'b0) - 1);

  state_e        r_state;
  logic [CW-1:0] r_count;
  logic          r_busy;
  logic          r_done;
  logic          w_zero;
  logic          w_step;

  cnt_zero_det #(
    .W (CW)
  ) u_zero_det (
    .i_count (r_count),
    .o_zero  (w_zero)
  );

  // step follows hold in the same cycle, so it cannot be a registered output.
  assign w_step = (r_state == ST_RUN) && !hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_RUN;
            r_count <= r4_mode ? LOAD_R4 : LOAD_R2;
            r_busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (abort) begin
            // The step issued this cycle still happens in the datapath,
            // but the sequence is dropped and no done is produced.
            r_state <= ST_IDLE;
            r_count <= '0;
            r_busy  <= 1'b0;
          end else if (w_step) begin
            if (w_zero) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_count <= r_count - CW'(1);
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_count <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign step  = w_step;
  assign last  = w_step && w_zero;
  assign count = r_count;
  assign zero  = w_zero;

endmodule

// File: tb/tb_iter_seq_ctrl.sv
module tb_iter_seq_ctrl;

  localparam int WIDTH = 8;
  localparam int CW    = 3;

  logic          clk;
  logic          rst;
  logic          start;
  logic          r4_mode;
  logic          hold;
  logic          abort;
  logic          busy;
  logic          step;
  logic          last;
  logic          done;
  logic [CW-1:0] count;
  logic          zero;

  iter_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .r4_mode (r4_mode),
    .hold    (hold),
    .abort   (abort),
    .busy    (busy),
    .step    (step),
    .last    (last),
    .done    (done),
    .count   (count),
    .zero    (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: iterations still to perform, and whether this
  // cycle is the completion cycle.
  int m_rem  = 0;
  int m_done = 0;

  int cyc_n    = 0;
  int t0       = 0;
  int done_cnt = 0;
  int done_at  = -1;

  logic [CW-1:0] s_count;
  logic          s_step, s_last, s_done, s_busy, s_zero;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs against the model
  // mid-cycle, then advance the model across the clock edge.
  task automatic cyc(input logic s, input logic m, input logic h, input logic a, input logic r);
    int e_cnt;
    int e_step;
    start = s; r4_mode = m; hold = h; abort = a; rst = r;
    #2;
    s_count = count; s_step = step; s_last = last;
    s_done  = done;  s_busy = busy; s_zero = zero;
    e_cnt  = (m_rem > 0) ? m_rem - 1 : 0;
    e_step = (m_rem > 0 && !h) ? 1 : 0;
    chk("count", 32'(s_count), 32'(e_cnt));
    chk("zero",  32'(s_zero),  32'(e_cnt == 0));
    chk("busy",  32'(s_busy),  32'(m_rem > 0 || m_done != 0));
    chk("step",  32'(s_step),  32'(e_step));
    chk("last",  32'(s_last),  32'(e_step == 1 && m_rem == 1));
    chk("done",  32'(s_done),  32'(m_done));
    if (s_done === 1'b1) begin
      done_cnt++;
      done_at = cyc_n - t0;
    end
    @(posedge clk);
    if (r) begin
      m_rem = 0; m_done = 0;
    end else if (m_done != 0) begin
      m_done = 0;
    end else if (m_rem > 0) begin
      if (a) m_rem = 0;
      else if (!h) begin
        m_rem--;
        if (m_rem == 0) m_done = 1;
      end
    end else if (s) begin
      m_rem = m ? WIDTH / 2 : WIDTH;
    end
    cyc_n++;
    #1;
  endtask

  task automatic begin_scn();
    t0 = cyc_n; done_cnt = 0; done_at = -1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; r4_mode = 1'b0; hold = 1'b0; abort = 1'b0;
    @(posedge clk); #1;
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("rst_count", 32'(s_count), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_zero", 32'(s_zero), 32'd1);
    chk("rst_busy", 32'(s_busy), 32'd0);

    // Radix-4 basic run
    begin_scn();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (k <= 4) begin
        chk("r4_count", 32'(s_count), 32'(4 - k));
        chk("r4_step",  32'(s_step), 32'd1);
        chk("r4_last",  32'(s_last), 32'(k == 4));
      end
      if (k == 6) chk("r4_busy_end", 32'(s_busy), 32'd0);
    end
    chk("r4_done_at", 32'(done_at), 32'd5);
    chk("r4_done_cnt", 32'(done_cnt), 32'd1);

    // Radix-2 run
    begin_scn();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      if (k <= 8) chk("r2_count", 32'(s_count), 32'(8 - k));
    end
    chk("r2_done_at", 32'(done_at), 32'd9);
    chk("r2_done_cnt", 32'(done_cnt), 32'd1);

    // Radix-4 with hold in cycles 2-3
    begin_scn();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b0, 1'b0, (k == 2 || k == 3), 1'b0, 1'b0);
      if (k == 2 || k == 3) begin
        chk("hold_count", 32'(s_count), 32'd2);
        chk("hold_step",  32'(s_step), 32'd0);
      end
    end
    chk("hold_done_at", 32'(done_at), 32'd7);

    // Abort in cycle 2
    begin_scn();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      cyc(1'b0, 1'b0, 1'b0, (k == 2), 1'b0);
      if (k == 2) chk("abort_step", 32'(s_step), 32'd1);
      if (k == 3) begin
        chk("abort_busy",  32'(s_busy), 32'd0);
        chk("abort_count", 32'(s_count), 32'd0);
        chk("abort_zero",  32'(s_zero), 32'd1);
      end
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);

    // Start pulses during RUN (cycle 2) and DONE (cycle 5) are ignored
    begin_scn();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      cyc((k == 2 || k == 5), 1'b0, 1'b0, 1'b0, 1'b0);
      if (k == 3) chk("ign_count", 32'(s_count), 32'd1);
      if (k == 6) chk("ign_idle", 32'(s_busy), 32'd0);
    end
    chk("ign_done_cnt", 32'(done_cnt), 32'd1);
    chk("ign_done_at", 32'(done_at), 32'd5);

    // Reset in cycle 3, new start in cycle 4
    begin_scn();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      cyc((k == 4), 1'b1, (k == 3), (k == 3), (k == 3));
      if (k == 4) begin
        chk("rr_busy",  32'(s_busy), 32'd0);
        chk("rr_step",  32'(s_step), 32'd0);
        chk("rr_last",  32'(s_last), 32'd0);
        chk("rr_done",  32'(s_done), 32'd0);
        chk("rr_count", 32'(s_count), 32'd0);
        chk("rr_zero",  32'(s_zero), 32'd1);
      end
      if (k == 5) chk("rr_restart", 32'(s_count), 32'd3);
    end
    chk("rr_done_at", 32'(done_at), 32'd9);
    chk("rr_done_cnt", 32'(done_cnt), 32'd1);

    // Randomized traffic against the reference model
    for (int k = 0; k < 400; k++) begin
      cyc(($urandom_range(0, 99) < 30), $urandom_range(0, 1) == 1,
          ($urandom_range(0, 99) < 25), ($urandom_range(0, 99) < 6),
          ($urandom_range(0, 99) < 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
